// File: rtl/pulse_timer.sv
// Loadable up/down timer with pause, stop/retrigger and a one-cycle done pulse.
// Define PULSE_TIMER_RELOAD_EN to enable periodic auto-reload of the captured load value.
module pulse_timer #(
    parameter int W      = 4,
    parameter int PRESET = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         use_preset,
    input  logic [W-1:0] period,
    input  logic         up,
    input  logic         periodic,
    input  logic         pause,
    input  logic         stop,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] count
);
    // Handshake: start/stop/pause are level inputs sampled each rising edge with
    // priority rst > start > stop > pause > step; busy and done are registered.

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [W-1:0] PRESET_L = W'(PRESET);
    localparam logic [W-1:0] ONE      = W'(1);

    state_t       state;
    logic         up_q;
    logic [W-1:0] load_val;
    logic [W-1:0] next_count;

`ifdef PULSE_TIMER_RELOAD_EN
    logic         periodic_q;
    logic [W-1:0] reload_q;
`else
    logic         unused_periodic;
    assign unused_periodic = periodic;
`endif

    assign load_val = use_preset ? PRESET_L : period;
    assign busy     = (state == RUN);

    always_comb begin
        next_count = up_q ? (count + ONE) : (count - ONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
            up_q  <= 1'b0;
`ifdef PULSE_TIMER_RELOAD_EN
            periodic_q <= 1'b0;
            reload_q   <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (start) begin
                if (load_val != '0) begin
                    state <= RUN;
                    count <= load_val;
                    up_q  <= up;
`ifdef PULSE_TIMER_RELOAD_EN
                    periodic_q <= periodic;
                    reload_q   <= load_val;
`endif
                end else begin
                    // A zero-length run finishes immediately without ever raising busy.
                    state <= IDLE;
                    count <= '0;
                    done  <= 1'b1;
                end
            end else if (state == RUN) begin
                if (stop) begin
                    state <= IDLE;
                end else if (!pause) begin
                    if (next_count == '0) begin
                        done <= 1'b1;
`ifdef PULSE_TIMER_RELOAD_EN
                        if (periodic_q) begin
                            count <= reload_q;
                        end else begin
                            count <= '0;
                            state <= IDLE;
                        end
`else
                        count <= '0;
                        state <= IDLE;
`endif
                    end else begin
                        count <= next_count;
                    end
                end
            end
        end
    end

endmodule
